// File: rtl/led_pixel_serializer.sv
// Serializes FWFT-buffered pixels LSB-first onto DAI with DEN high for DW cycles, then a DEN-low gap; counts words per frame.
// Latency: word accepted at edge E shows bit0 after E+2; streaming throughput one word per DW+GAP_CYCLES cycles.
// Backpressure: pix_ready drops while the FIFO is full, while frame_sync is high, and while rst is high.
module led_pixel_serializer #(
    parameter int DW           = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CYCLES   = 1,
    parameter int FRAME_PIXELS = 256
) (
    input  logic                            DCK,
    input  logic                            rst,
    input  logic [DW-1:0]                   pix_data,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic                            frame_sync,
    output logic                            DAI,
    output logic                            DEN,
    output logic                            busy,
    output logic [$clog2(FRAME_PIXELS)-1:0] pix_cnt,
    output logic                            frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DW);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int CW = $clog2(FRAME_PIXELS);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          den_q, den_d, dai_q, dai_d, done_q, done_d;
    logic          fifo_empty, fifo_full, push, pop, last_bit, gap_last, word_done;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pix_ready  = !fifo_full && !frame_sync && !rst;
    assign push       = pix_valid && pix_ready;
    assign last_bit   = (bit_q == BW'(DW - 1));
    assign gap_last   = (gap_q == GW'(GAP_CYCLES - 1));

    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            cnt_q    <= '0;
            den_q    <= 1'b0;
            dai_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            den_q    <= den_d;
            dai_q    <= dai_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge DCK) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= pix_data;
    end

    // frame_sync blocks every pop, so a flushed FIFO never feeds the shifter.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !frame_sync) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_sync || last_bit) state_d = GAP;
            end
            GAP: begin
                if (gap_last) begin
                    if (!fifo_empty && !frame_sync) begin
                        pop     = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        shift_d = shift_q;
        bit_d   = bit_q;
        if (pop) begin
            shift_d = mem_q[rd_ptr_q[AW-1:0]];
            bit_d   = '0;
        end else if (state_q == SHIFT) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
        end
        gap_d    = (state_q == GAP && !gap_last) ? gap_q + GW'(1) : '0;
        wr_ptr_d = frame_sync ? '0 : wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d = frame_sync ? '0 : rd_ptr_q + (AW + 1)'(pop);
    end

    // A word counts only when DEN falls naturally; an abort by frame_sync suppresses it.
    always_comb begin
        den_d     = (state_q == SHIFT) && !frame_sync;
        dai_d     = den_d && shift_q[0];
        word_done = den_q && !den_d && !frame_sync;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (frame_sync) begin
            cnt_d = '0;
        end else if (word_done) begin
            if (cnt_q == CW'(FRAME_PIXELS - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign DAI        = dai_q;
    assign DEN        = den_q;
    assign busy       = !fifo_empty || (state_q == SHIFT);
    assign pix_cnt    = cnt_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_led_pixel_serializer.sv
// Bench for led_pixel_serializer: a serial-line scoreboard rebuilds words from DEN/DAI and checks order, lengths and frame counts.
module tb_led_pixel_serializer;
    logic        DCK = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pix_data = '0, p3_data = '0;
    logic        pix_valid = 1'b0, p3_valid = 1'b0, frame_sync = 1'b0, fs3 = 1'b0;
    logic        pix_ready, p3_ready, DAI, DEN, busy, dai3, den3, busy3, frame_done, done3;
    logic [7:0]  pix_cnt, cnt3;
    int          checks = 0, errors = 0;
    bit          saw_not_ready = 1'b0;

    always #5 DCK = ~DCK;

    led_pixel_serializer #(.DW(16), .FIFO_DEPTH(4), .GAP_CYCLES(1), .FRAME_PIXELS(256)) dut (
        .DCK(DCK), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_sync(frame_sync), .DAI(DAI), .DEN(DEN), .busy(busy), .pix_cnt(pix_cnt),
        .frame_done(frame_done)
    );

    led_pixel_serializer #(.DW(16), .FIFO_DEPTH(4), .GAP_CYCLES(3), .FRAME_PIXELS(256)) dut3 (
        .DCK(DCK), .rst(rst), .pix_data(p3_data), .pix_valid(p3_valid), .pix_ready(p3_ready),
        .frame_sync(fs3), .DAI(dai3), .DEN(den3), .busy(busy3), .pix_cnt(cnt3),
        .frame_done(done3)
    );

    // Reference model: accepted words in order, words completed in the frame, serial-line run lengths.
    logic [15:0] exp_q[$];
    int          gaps_q[$];
    int          mcnt = 0, hi_len = 0, lo_len = 100, rise_cnt = 0, done_seen = 0;
    logic        prev_den = 1'b0;
    logic [15:0] cur_word = '0, exp_w;

    always @(negedge DCK) begin
        if (rst) begin
            exp_q.delete();
            mcnt = 0; hi_len = 0; lo_len = 100; prev_den = 1'b0;
        end else begin
            if (DEN) begin
                if (!prev_den) begin
                    checks++;
                    if (lo_len < 1) begin errors++; $display("FAIL mon_gap_len: got %0d expected >=1", lo_len); end
                    gaps_q.push_back(lo_len);
                    rise_cnt++;
                    lo_len = 0;
                end
                if (hi_len < 16) cur_word[hi_len] = DAI;
                hi_len++;
            end else begin
                if (prev_den) begin
                    checks++;
                    if (hi_len != 16) begin errors++; $display("FAIL mon_den_len: got %0d expected 16", hi_len); end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL mon_extra_word: got %h expected none", cur_word);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (cur_word !== exp_w) begin errors++; $display("FAIL mon_word: got %h expected %h", cur_word, exp_w); end
                    end
                    mcnt = (mcnt + 1) % 256;
                    checks++;
                    if (frame_done !== (mcnt == 0)) begin
                        errors++; $display("FAIL mon_frame_done_fall: got %b expected %b", frame_done, (mcnt == 0));
                    end
                    hi_len = 0;
                end else begin
                    checks++;
                    if (frame_done !== 1'b0) begin errors++; $display("FAIL mon_frame_done_idle: got %b expected 0", frame_done); end
                end
                lo_len++;
            end
            if (frame_done === 1'b1) done_seen++;
            checks++;
            if (pix_cnt !== 8'(mcnt)) begin errors++; $display("FAIL mon_pix_cnt: got %0d expected %0d", pix_cnt, mcnt); end
            prev_den = DEN;
            if (frame_sync) begin
                exp_q.delete();
                mcnt = 0;
                if (DEN) begin hi_len = 0; lo_len = 0; prev_den = 1'b0; end
            end else if (pix_valid && pix_ready) begin
                exp_q.push_back(pix_data);
            end
        end
    end

    task automatic push_one(input logic [15:0] w);
        int t = 0;
        pix_data  = w;
        pix_valid = 1'b1;
        @(negedge DCK);
        while (pix_ready !== 1'b1 && t < 100) begin
            saw_not_ready = 1'b1;
            t++;
            @(negedge DCK);
        end
        if (t >= 100) begin checks++; errors++; $display("FAIL push_timeout: got ready=%b expected 1", pix_ready); end
        @(posedge DCK); #1;
    endtask

    task automatic push_n(input int n, input bit stalls);
        for (int i = 0; i < n; i++) begin
            push_one(16'($urandom));
            if (stalls && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                @(posedge DCK); #1;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge DCK); #1;
        while (!(busy === 1'b0 && DEN === 1'b0) && t < 500) begin
            t++;
            @(negedge DCK); #1;
        end
        if (t >= 500) begin checks++; errors++; $display("FAIL idle_timeout: got busy=%b expected 0", busy); end
        repeat (2) @(negedge DCK);
        @(posedge DCK); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge DCK);
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b expected 0", pix_ready); end
        checks++; if (DEN !== 1'b0) begin errors++; $display("FAIL reset_den: got %b expected 0", DEN); end
        checks++; if (DAI !== 1'b0) begin errors++; $display("FAIL reset_dai: got %b expected 0", DAI); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (pix_cnt !== 8'd0) begin errors++; $display("FAIL reset_pix_cnt: got %0d expected 0", pix_cnt); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        @(posedge DCK); #1;
        rst = 1'b0;
        @(negedge DCK);
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", pix_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
        @(posedge DCK); #1;
    endtask

    task automatic test_single_word();
        logic [15:0] w;
        logic        exp_den;
        w = 16'hA5C3;
        push_one(w);
        pix_valid = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            @(negedge DCK);
            exp_den = (k >= 2 && k <= 17);
            checks++;
            if (DEN !== exp_den) begin errors++; $display("FAIL single_den[%0d]: got %b expected %b", k, DEN, exp_den); end
            if (exp_den) begin
                checks++;
                if (DAI !== w[k-2]) begin errors++; $display("FAIL single_dai[%0d]: got %b expected %b", k - 2, DAI, w[k-2]); end
            end
            if (k == 0) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
            end
        end
        checks++; if (pix_cnt !== 8'd1) begin errors++; $display("FAIL single_pix_cnt: got %0d expected 1", pix_cnt); end
        @(posedge DCK); #1;
    endtask

    task automatic test_stream8();
        int c0;
        c0 = mcnt;
        saw_not_ready = 1'b0;
        gaps_q.delete();
        push_n(8, 1'b0);
        wait_idle();
        checks++; if (saw_not_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_drop: got %b expected 1", saw_not_ready); end
        checks++; if (gaps_q.size() != 8) begin errors++; $display("FAIL stream_word_starts: got %0d expected 8", gaps_q.size()); end
        for (int i = 1; i < 8 && i < gaps_q.size(); i++) begin
            checks++;
            if (gaps_q[i] != 1) begin errors++; $display("FAIL stream_gap[%0d]: got %0d expected 1", i, gaps_q[i]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_lost_words: got %0d expected 0", exp_q.size()); end
        checks++; if (pix_cnt !== 8'((c0 + 8) % 256)) begin errors++; $display("FAIL stream_pix_cnt: got %0d expected %0d", pix_cnt, (c0 + 8) % 256); end
    endtask

    task automatic test_frame();
        int c0;
        c0 = mcnt;
        done_seen = 0;
        push_n(256 - c0, 1'b1);
        wait_idle();
        checks++; if (done_seen != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", done_seen); end
        checks++; if (pix_cnt !== 8'd0) begin errors++; $display("FAIL frame_pix_cnt: got %0d expected 0", pix_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL frame_lost_words: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_frame_sync();
        int rc0, d0, t;
        rc0 = rise_cnt;
        d0  = done_seen;
        t   = 0;
        push_n(5, 1'b0);
        @(negedge DCK); #1;
        while (rise_cnt != rc0 + 3 && t < 300) begin
            t++;
            @(negedge DCK); #1;
        end
        checks++; if (t >= 300) begin errors++; $display("FAIL fsync_wait_word3: got %0d starts expected %0d", rise_cnt - rc0, 3); end
        repeat (6) @(negedge DCK);
        @(posedge DCK); #1;
        frame_sync = 1'b1;
        @(posedge DCK); #1;
        frame_sync = 1'b0;
        @(negedge DCK);
        checks++; if (DEN !== 1'b0) begin errors++; $display("FAIL fsync_den: got %b expected 0", DEN); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fsync_busy: got %b expected 0", busy); end
        checks++; if (pix_cnt !== 8'd0) begin errors++; $display("FAIL fsync_pix_cnt: got %0d expected 0", pix_cnt); end
        repeat (4) @(negedge DCK);
        #1;
        checks++; if (done_seen != d0) begin errors++; $display("FAIL fsync_frame_done: got %0d expected %0d", done_seen, d0); end
        @(posedge DCK); #1;
        push_n(1, 1'b0);
        wait_idle();
        checks++; if (pix_cnt !== 8'd1) begin errors++; $display("FAIL fsync_next_word: got %0d expected 1", pix_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fsync_flush: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        int t = 0;
        push_one(16'hFFFF);
        pix_valid = 1'b0;
        @(negedge DCK);
        while (DEN !== 1'b1 && t < 50) begin t++; @(negedge DCK); end
        repeat (3) @(negedge DCK);
        #2 rst = 1'b1;
        #1;
        checks++; if (DEN !== 1'b0) begin errors++; $display("FAIL arst_den: got %b expected 0", DEN); end
        checks++; if (DAI !== 1'b0) begin errors++; $display("FAIL arst_dai: got %b expected 0", DAI); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b expected 0", pix_ready); end
        @(negedge DCK);
        #2 rst = 1'b0;
        @(negedge DCK);
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL arst_post_ready: got %b expected 1", pix_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_post_busy: got %b expected 0", busy); end
        checks++; if (pix_cnt !== 8'd0) begin errors++; $display("FAIL arst_post_pix_cnt: got %0d expected 0", pix_cnt); end
        checks++; if (DEN !== 1'b0) begin errors++; $display("FAIL arst_post_den: got %b expected 0", DEN); end
        @(posedge DCK); #1;
    endtask

    task automatic test_gap3();
        logic [15:0] sent[$];
        logic [15:0] words[$];
        int          his[$];
        int          los[$];
        logic [15:0] cw;
        int          hl, ll;
        logic        pd, started;
        cw = '0; hl = 0; ll = 0; pd = 1'b0; started = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int t = 0;
                    p3_data  = 16'($urandom);
                    sent.push_back(p3_data);
                    p3_valid = 1'b1;
                    @(negedge DCK);
                    while (p3_ready !== 1'b1 && t < 100) begin t++; @(negedge DCK); end
                    @(posedge DCK); #1;
                end
                p3_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge DCK);
                    if (den3) begin
                        if (!pd && started) los.push_back(ll);
                        if (hl < 16) cw[hl] = dai3;
                        hl++;
                        ll = 0;
                        started = 1'b1;
                    end else begin
                        if (pd) begin
                            his.push_back(hl);
                            words.push_back(cw);
                            hl = 0;
                        end
                        ll++;
                    end
                    pd = den3;
                end
            end
        join
        checks++; if (words.size() != 4) begin errors++; $display("FAIL gap3_word_count: got %0d expected 4", words.size()); end
        for (int i = 0; i < 4 && i < words.size(); i++) begin
            checks++;
            if (words[i] !== sent[i]) begin errors++; $display("FAIL gap3_word[%0d]: got %h expected %h", i, words[i], sent[i]); end
            checks++;
            if (his[i] != 16) begin errors++; $display("FAIL gap3_den_len[%0d]: got %0d expected 16", i, his[i]); end
        end
        checks++; if (los.size() != 3) begin errors++; $display("FAIL gap3_gap_count: got %0d expected 3", los.size()); end
        for (int i = 0; i < los.size(); i++) begin
            checks++;
            if (los[i] != 3) begin errors++; $display("FAIL gap3_gap_len[%0d]: got %0d expected 3", i, los[i]); end
        end
        checks++; if (cnt3 !== 8'd4) begin errors++; $display("FAIL gap3_pix_cnt: got %0d expected 4", cnt3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL gap3_busy: got %b expected 0", busy3); end
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_word();
        test_stream8();
        test_frame();
        test_frame_sync();
        test_async_reset();
        test_gap3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
